u_imem: RTL

//  Instruction memory responder on the IFU fetch port: answers ins_a/ins_e with ins one cycle later (synchronous SRAM timing).

---
 rtl/u_imem_pkg.sv | 22 ++
 rtl/u_imem_ld.sv | 114 +++++++++++
 rtl/u_imem.sv | 107 ++++++++++
 3 files changed

// File: rtl/u_imem_pkg.sv
// u_imem_pkg: shared definitions for the instruction memory responder.
//   NOP_WORD_DEF : default word returned on a faulted fetch (addi x0,x0,0)
//   ld_state_e   : loader FSM states
//   parity32     : even-parity bit of a 32-bit word
// Optional feature macro: IMEM_PARITY_EN (see u_imem.sv).
package u_imem_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_BYTE   = 2'd1,
    LD_COMMIT = 2'd2,
    LD_FULL   = 2'd3
  } ld_state_e;

  // Bit that makes the total number of ones in {parity, d} even.
  function automatic logic parity32(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/u_imem_ld.sv
// u_imem_ld: byte-stream program loader. Assembles little-endian bytes into
// 32-bit words and emits one write per word, starting from word 0.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   ld_start   : restart the load at word 0 (highest priority input)
//   ld_valid   : ld_byte is valid; accepted only while state == LD_BYTE
//   ld_byte    : program byte, lane order 0..3 within a word
//   ld_finish  : end of stream; a partial word is committed zero-padded
//   we/waddr/wdata : array write strobe, word address and data
//   ld_words   : words committed since the last ld_start
//   state      : current FSM state (drives ld_ready/ld_busy/ld_full in the top)
// Handshake: a byte transfers on a rising edge where state == LD_BYTE and
// ld_valid == 1; ld_ready is simply (state == LD_BYTE), it never depends on
// ld_valid.
module u_imem_ld
  import u_imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_finish,
  output logic                  we,
  output logic [DEPTH_LOG2-1:0] waddr,
  output logic [31:0]           wdata,
  output logic [DEPTH_LOG2:0]   ld_words,
  output ld_state_e             state
);

  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = {DEPTH_LOG2{1'b1}};

  ld_state_e             state_nx;
  logic [DEPTH_LOG2-1:0] wptr, wptr_nx;
  logic [1:0]            bcnt, bcnt_nx;
  logic [31:0]           word, word_nx;
  logic                  fin_pend, fin_pend_nx;
  logic [DEPTH_LOG2:0]   words_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LD_IDLE;
      wptr     <= '0;
      bcnt     <= '0;
      word     <= '0;
      fin_pend <= 1'b0;
      ld_words <= '0;
    end else begin
      state    <= state_nx;
      wptr     <= wptr_nx;
      bcnt     <= bcnt_nx;
      word     <= word_nx;
      fin_pend <= fin_pend_nx;
      ld_words <= words_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wptr_nx     = wptr;
    bcnt_nx     = bcnt;
    word_nx     = word;
    fin_pend_nx = fin_pend;
    words_nx    = ld_words;
    we          = 1'b0;
    if (ld_start) begin
      state_nx    = LD_BYTE;
      wptr_nx     = '0;
      bcnt_nx     = '0;
      word_nx     = '0;
      fin_pend_nx = 1'b0;
      words_nx    = '0;
    end else begin
      case (state)
        LD_BYTE: begin
          if (ld_valid) begin
            word_nx[{bcnt, 3'b000} +: 8] = ld_byte;
            bcnt_nx = bcnt + 2'd1;
          end
          // A byte arriving with ld_finish still belongs to the final word.
          if (ld_valid && bcnt == 2'd3) begin
            state_nx    = LD_COMMIT;
            fin_pend_nx = ld_finish;
          end else if (ld_finish) begin
            if (ld_valid || bcnt != 2'd0) begin
              state_nx    = LD_COMMIT;
              fin_pend_nx = 1'b1;
            end else begin
              state_nx = LD_IDLE;
            end
          end
        end
        LD_COMMIT: begin
          we          = 1'b1;
          wptr_nx     = wptr + 1'b1;
          words_nx    = ld_words + 1'b1;
          bcnt_nx     = '0;
          word_nx     = '0;  // unfilled lanes of the next word read as zero
          fin_pend_nx = 1'b0;
          if (wptr == LAST_ADDR) state_nx = LD_FULL;
          else if (fin_pend)     state_nx = LD_IDLE;
          else                   state_nx = LD_BYTE;
        end
        default: ;  // LD_IDLE, LD_FULL: bytes ignored, leave only via ld_start
      endcase
    end
  end

  assign waddr = wptr;
  assign wdata = word;

endmodule

// File: rtl/u_imem.sv
// u_imem: instruction memory responder on the IFU fetch port.
// Synchronous-read word array (1R1W) filled by the u_imem_ld byte loader.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   ins_a/ins_e : fetch byte address / enable; response one cycle later
//   ins/ins_err : fetch data and fault flag; both hold while ins_e == 0
//   ld_*        : loader byte stream, status and committed-word count
// Macro IMEM_PARITY_EN: store an even-parity bit with every word and flag a
// parity mismatch on fetch as a fault. Undefined: 32-bit array, address
// faults only.
module u_imem
  import u_imem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         ins_a,
  input  logic                ins_e,
  output logic [31:0]         ins,
  output logic                ins_err,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [7:0]          ld_byte,
  output logic                ld_ready,
  input  logic                ld_finish,
  output logic                ld_busy,
  output logic                ld_full,
  output logic [DEPTH_LOG2:0] ld_words
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef IMEM_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  logic [MW-1:0]         mem [DEPTH];
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [31:0]           wdata;
  ld_state_e             ld_state;

  u_imem_ld #(.DEPTH_LOG2(DEPTH_LOG2)) u_ld (
    .clk       (clk),
    .rst       (rst),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_finish (ld_finish),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .ld_words  (ld_words),
    .state     (ld_state)
  );

  assign ld_ready = (ld_state == LD_BYTE);
  assign ld_busy  = (ld_state == LD_BYTE) || (ld_state == LD_COMMIT);
  assign ld_full  = (ld_state == LD_FULL);

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
`ifdef IMEM_PARITY_EN
      mem[waddr] <= {parity32(wdata), wdata};
`else
      mem[waddr] <= wdata;
`endif
    end
  end

  logic [DEPTH_LOG2-1:0] raddr;
  logic                  addr_fault;
  logic                  data_fault;
  logic [MW-1:0]         rword;

  assign raddr = ins_a[DEPTH_LOG2+1:2];
  // Shift form stays legal when the array covers the whole 16-bit space.
  assign addr_fault = (ins_a[1:0] != 2'b00) || ((ins_a >> (DEPTH_LOG2 + 2)) != 16'd0);
  assign rword = mem[raddr];
`ifdef IMEM_PARITY_EN
  assign data_fault = ^rword;
`else
  assign data_fault = 1'b0;
`endif

  // Read is sampled at the same edge as a same-word write, so the old
  // contents are returned and the new word is seen on the next fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins     <= '0;
      ins_err <= 1'b0;
    end else if (ins_e) begin
      if (addr_fault || data_fault) begin
        ins     <= NOP_WORD;
        ins_err <= 1'b1;
      end else begin
        ins     <= rword[31:0];
        ins_err <= 1'b0;
      end
    end
  end

endmodule
